// File: rtl/pio_pkg.sv
// Shared constants for the Avalon PIO capture block: register offsets,
// bus widths and the edge-selection encoding.
package pio_pkg;

  localparam int unsigned AVS_ADDR_W = 3;
  localparam int unsigned AVS_DATA_W = 32;

  localparam logic [AVS_ADDR_W-1:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [AVS_ADDR_W-1:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [AVS_ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [AVS_ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [AVS_ADDR_W-1:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [AVS_ADDR_W-1:0] ADDR_OUT_CLR  = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce.sv
// One PIO bit: 2-flop synchronizer followed by a stable-count debouncer.
// DEBOUNCE_CYCLES == 0 passes the synchronized value straight through.
module pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        IN_RESET_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic deb_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IN_RESET_VAL;
      sync2_q <= IN_RESET_VAL;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb_o = sync2_q;
  end else begin : g_count
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;

    // Accept the new level on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        deb_q <= IN_RESET_VAL;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb_o = deb_q;
  end

endmodule

// File: rtl/avalon_pio_capture.sv
// Avalon-MM PIO with debounced inputs, edge capture, set/clear outputs and
// a masked level interrupt. Reads are registered with one cycle latency.
module avalon_pio_capture
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter int unsigned      EDGE_MODE       = EDGE_RISING,
  parameter logic [WIDTH-1:0] IN_RESET_VAL    = '1,
  parameter logic [WIDTH-1:0] OUT_RESET_VAL   = '0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [AVS_ADDR_W-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [AVS_DATA_W-1:0] avs_writedata,
  output logic [AVS_DATA_W-1:0] avs_readdata,
  input  logic [WIDTH-1:0]      pio_in,
  output logic [WIDTH-1:0]      pio_out,
  output logic                  irq
);

  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      din_prev_q;
  logic [WIDTH-1:0]      data_out_q, data_out_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0]      cap_q, cap_d;
  logic [WIDTH-1:0]      edge_hit;
  logic [WIDTH-1:0]      cap_clr;
  logic [WIDTH-1:0]      wdata;
  logic [AVS_DATA_W-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IN_RESET_VAL    (IN_RESET_VAL[i])
    ) u_debounce (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .pin_i (pio_in[i]),
      .deb_o (data_in[i])
    );
  end

  assign wdata        = avs_writedata[WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  // Edge detect on the debounced value against its previous-cycle copy.
  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      EDGE_FALLING: edge_hit = din_prev_q & ~data_in;
      EDGE_ANY:     edge_hit = din_prev_q ^ data_in;
      default:      edge_hit = ~din_prev_q & data_in;
    endcase
  end

  // Write decode; a new edge wins over a same-cycle clear.
  always_comb begin
    data_out_d = data_out_q;
    mask_d     = mask_q;
    cap_clr    = '0;
    if (avs_write) begin
      case (avs_address)
        ADDR_DATA_OUT: data_out_d = wdata;
        ADDR_IRQ_MASK: mask_d     = wdata;
        ADDR_EDGE_CAP: cap_clr    = wdata;
        ADDR_OUT_SET:  data_out_d = data_out_q | wdata;
        ADDR_OUT_CLR:  data_out_d = data_out_q & ~wdata;
        default:       ;
      endcase
    end
    cap_d = (cap_q & ~cap_clr) | edge_hit;
    irq_d = |(cap_q & mask_q);
  end

  // Read mux samples pre-write register contents.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA_IN:  rdata_d = AVS_DATA_W'(data_in);
        ADDR_DATA_OUT: rdata_d = AVS_DATA_W'(data_out_q);
        ADDR_IRQ_MASK: rdata_d = AVS_DATA_W'(mask_q);
        ADDR_EDGE_CAP: rdata_d = AVS_DATA_W'(cap_q);
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      din_prev_q <= IN_RESET_VAL;
      data_out_q <= OUT_RESET_VAL;
      mask_q     <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      din_prev_q <= data_in;
      data_out_q <= data_out_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign pio_out      = data_out_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: doc/avalon_pio_capture.md
AVALON_PIO_CAPTURE -- requirements
Module: avalon_pio_capture

Interface
REQ-001 Parameter WIDTH, 10: number of PIO bits; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, 4: stable-cycle count required before an input change is accepted; 0 bypasses debounce.
REQ-003 Parameter EDGE_MODE, 0: edge type to capture; 0 rising, 1 falling, 2 any.
REQ-004 Parameter IN_RESET_VAL, all ones: reset value of the synchronizer and debounced-input registers.
REQ-005 Parameter OUT_RESET_VAL, 0: reset value of the output register.
REQ-006 Port clk_clk, input, 1: single clock; all state is on its rising edge.
REQ-007 Port reset_reset_n, input, 1: asynchronous reset, active-low.
REQ-008 Port avs_address, input, 3: Avalon-MM word address.
REQ-009 Port avs_read / avs_write, input, 1 each: Avalon-MM strobes; no waitrequest.
REQ-010 Port avs_writedata, input, 32: write data; bits above WIDTH are ignored.
REQ-011 Port avs_readdata, output, 32: read data, zero-extended above WIDTH.
REQ-012 Port pio_in, input, WIDTH: asynchronous external inputs (switches, pushbuttons).
REQ-013 Port pio_out, output, WIDTH: registered outputs (LEDs, HEX segments).
REQ-014 Port irq, output, 1: level interrupt.

Function
REQ-015 Register map: 0 DATA_IN (RO, debounced input); 1 DATA_OUT (RW); 2 IRQ_MASK (RW); 3 EDGE_CAP (R, write-1-to-clear); 4 OUT_SET (WO, OR into DATA_OUT); 5 OUT_CLR (WO, AND-NOT into DATA_OUT); 6-7 read 0, writes ignored.
REQ-016 Read latency is fixed at 1 cycle: avs_readdata is registered and valid on the cycle after avs_read; it holds its value otherwise.
REQ-017 Writes take effect at the clock edge where avs_write is sampled high; pio_out reflects DATA_OUT with no further delay.
REQ-018 Each pio_in bit passes through a 2-flop synchronizer before debounce.
REQ-019 Debounce is per bit: the counter resets whenever the synchronized value equals the debounced value; otherwise it increments; at DEBOUNCE_CYCLES the debounced bit takes the synchronized value and the counter clears.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES cycles never changes DATA_IN; pin-to-DATA_IN latency is 2+DEBOUNCE_CYCLES cycles (2 when bypassed).
REQ-021 An edge of the type selected by EDGE_MODE on a debounced bit sets that EDGE_CAP bit one cycle later; the bit stays set until cleared by a write.
REQ-022 If an edge and a clearing write to the same EDGE_CAP bit fall in the same cycle, the bit ends set.
REQ-023 If OUT_SET and OUT_CLR target the same bit, the single write in that cycle determines the result; the two cannot coincide.
REQ-024 irq is registered and equals the OR of (EDGE_CAP AND IRQ_MASK), one cycle after either operand changes.
REQ-025 Simultaneous avs_read and avs_write: the write proceeds, and the read returns pre-write contents.

Reset
REQ-026 While reset_reset_n is low: synchronizers and DATA_IN are IN_RESET_VAL; DATA_OUT and pio_out are OUT_RESET_VAL; IRQ_MASK, EDGE_CAP, counters, avs_readdata and irq are 0.
REQ-027 No edge is captured due to reset release; a transaction in progress when reset asserts is discarded.

Structure
REQ-028 Package pio_pkg holds the register offset constants and the EDGE_MODE encoding.
REQ-029 Sub-module pio_debounce (one bit: synchronizer plus counter) is instantiated WIDTH times through a generate loop.

Verification
REQ-030 WIDTH=10, DEBOUNCE_CYCLES=4, pio_in[0] 1->0 held 6 cycles -> DATA_IN[0]=0 after 6 cycles; with EDGE_MODE=1, EDGE_CAP=0x001.
REQ-031 pio_in[3] pulse of 3 cycles -> DATA_IN and EDGE_CAP unchanged.
REQ-032 Write DATA_OUT=0x0F0, OUT_SET=0x003, OUT_CLR=0x010 -> pio_out=0x0E3; read DATA_OUT returns 0x000000E3.
REQ-033 IRQ_MASK=0x001 with EDGE_CAP[0] set -> irq=1; write EDGE_CAP=0x001 -> irq=0 one cycle later; repeat with an edge in the same cycle as the clear -> bit stays set and irq stays 1.
REQ-034 Assert reset mid-debounce with DATA_OUT=0x3FF -> pio_out=0x000, DATA_IN=0x3FF, irq=0 immediately; no EDGE_CAP bits are set after release.
